// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store + writeback stage.
package lsu_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    // Low address bits that must be zero for a word access.
    localparam logic [XLEN-1:0] ADDR_ALIGN_MASK = 32'h0000_0003;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } lsu_state_e;
endpackage

// File: rtl/lsu_timeout_ctr.sv
// Cycle counter used to bound the wait for a data-memory acknowledge.
module lsu_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Expires on the LIMIT-th enabled cycle after a clear.
    assign o_expired = (r_cnt == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/lsu_wb.sv
// Load/store and writeback stage: one ALU op per handshake, word memory access, 1-cycle writeback.
// Optional LSU_TIMEOUT_EN bounds the wait for dmem_ack to TIMEOUT_CYCLES.
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [XLEN-1:0]      alu_mem_addr,
    input  logic [XLEN-1:0]      alu_store_data,
    input  logic                 alu_load,
    input  logic                 alu_store,
    input  logic                 alu_reg_we,
    input  logic [REG_IDX_W-1:0] alu_rd,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 lsu_err
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lsu_wb: TIMEOUT_CYCLES must be >= 1");
    end

    lsu_state_e           r_state, w_state_nxt;
    logic                 r_dmem_we;
    logic [XLEN-1:0]      r_dmem_addr, r_dmem_wdata, r_wb_data;
    logic [REG_IDX_W-1:0] r_rd, r_wb_rd;
    logic                 r_wb_valid, r_wb_we, r_lsu_err;
    logic                 w_accept, w_is_mem, w_bad, w_start, w_ack, w_timeout;

    assign alu_ready  = (r_state == IDLE);
    assign dmem_req   = (r_state == REQ);
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_we      = r_wb_we;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign lsu_err    = r_lsu_err;

    assign w_accept = alu_valid & alu_ready;
    assign w_is_mem = alu_load | alu_store;
    // Load+store together is as unusable as a misaligned address.
    assign w_bad    = w_is_mem & (((alu_mem_addr & ADDR_ALIGN_MASK) != '0) | (alu_load & alu_store));
    assign w_start  = w_accept & w_is_mem & ~w_bad;
    assign w_ack    = (r_state == REQ) & dmem_ack;

`ifdef LSU_TIMEOUT_EN
    logic w_expired;

    lsu_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_start),
        .i_en      (r_state == REQ),
        .o_expired (w_expired)
    );

    // An ack on the final cycle still completes the access.
    assign w_timeout = (r_state == REQ) & w_expired & ~dmem_ack;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = REQ;
            REQ:  if (w_ack || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_rd         <= '0;
        end else if (w_start) begin
            r_dmem_we    <= alu_store;
            r_dmem_addr  <= alu_mem_addr & ~ADDR_ALIGN_MASK;
            r_dmem_wdata <= alu_store_data;
            r_rd         <= alu_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_lsu_err  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_lsu_err  <= (w_accept & w_bad) | w_timeout;
            if (w_accept && !w_is_mem && alu_reg_we) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= (alu_rd != '0);
                r_wb_rd    <= alu_rd;
                r_wb_data  <= alu_result;
            end else if (w_ack && !r_dmem_we) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= (r_rd != '0);
                r_wb_rd    <= r_rd;
                r_wb_data  <= dmem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_lsu_wb.sv
// Scoreboard bench for lsu_wb: stimulus queues expected writebacks/errors, a monitor checks them.
module tb_lsu_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [31:0] alu_result, alu_mem_addr, alu_store_data;
    logic        alu_load, alu_store, alu_reg_we;
    logic [4:0]  alu_rd;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_err;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t wb_q[$];
    int      err_exp = 0;
    int      n_pass  = 0;
    int      n_tot   = 0;

    lsu_wb #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
        .alu_mem_addr(alu_mem_addr), .alu_store_data(alu_store_data),
        .alu_load(alu_load), .alu_store(alu_store), .alu_reg_we(alu_reg_we), .alu_rd(alu_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_err(lsu_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic we, input logic [4:0] rd);
        alu_valid = 1'b1; alu_load = ld; alu_store = st; alu_mem_addr = addr;
        alu_result = res; alu_store_data = sd; alu_reg_we = we; alu_rd = rd;
    endtask

    task automatic idle_in();
        alu_valid = 1'b0; alu_load = 1'b0; alu_store = 1'b0; alu_reg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        alu_result = '0; alu_mem_addr = '0; alu_store_data = '0; alu_rd = '0;
        idle_in();
        fork
            forever begin : monitor
                @(negedge clk);
                if (wb_valid) begin
                    if (wb_q.size() == 0) begin
                        chk("unexpected_wb", 32'd1, 32'd0);
                    end else begin
                        wb_exp_t e;
                        e = wb_q.pop_front();
                        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                        chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                        chk("wb_data", wb_data, e.data);
                    end
                end
                if (lsu_err) begin
                    chk("err_expected", (err_exp > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (err_exp > 0) err_exp--;
                    chk("err_with_wb", {31'd0, wb_valid}, 32'd0);
                end
            end
        join_none

        #12;
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_outs", {dmem_we, wb_valid, wb_we, lsu_err}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        tick(); rst = 1'b0;

        // Two back-to-back ALU writebacks.
        drive(0, 0, 32'h0, 32'h5, 32'h0, 1, 5'd3);
        wb_q.push_back('{5'd3, 1'b1, 32'h5});
        tick();
        chk("b2b_ready", {31'd0, alu_ready}, 32'd1);
        chk("b2b_wb1", {31'd0, wb_valid}, 32'd1);
        drive(0, 0, 32'h0, 32'hF, 32'h0, 1, 5'd4);
        wb_q.push_back('{5'd4, 1'b1, 32'hF});
        tick(); idle_in();
        chk("b2b_wb2", {31'd0, wb_valid}, 32'd1);
        tick();

        // Load at 0x100, acked on the third request cycle.
        drive(1, 0, 32'h100, 32'h0, 32'h0, 1, 5'd7);
        wb_q.push_back('{5'd7, 1'b1, 32'hDEAD_BEEF});
        tick(); idle_in();
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_we", {31'd0, dmem_we}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            chk("ld_req_held", {31'd0, dmem_req}, 32'd1);
            chk("ld_ready_low", {31'd0, alu_ready}, 32'd0);
            if (c == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
            tick();
        end
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        chk("ld_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("ld_ready_back", {31'd0, alu_ready}, 32'd1);
        chk("ld_wb_pulse", {31'd0, wb_valid}, 32'd1);

        // Store with ack on the first request cycle.
        drive(0, 1, 32'h200, 32'h0, 32'h1234_5678, 0, 5'd0);
        tick(); idle_in();
        chk("st_req", {31'd0, dmem_req}, 32'd1);
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_addr", dmem_addr, 32'h200);
        chk("st_wdata", dmem_wdata, 32'h1234_5678);
        dmem_ack = 1'b1;
        tick(); dmem_ack = 1'b0;
        chk("st_ready_2cyc", {31'd0, alu_ready}, 32'd1);
        chk("st_no_wb", {31'd0, wb_valid}, 32'd0);

        // Misaligned load, then illegal load+store, then load to x0.
        drive(1, 0, 32'h102, 32'h0, 32'h0, 1, 5'd9);
        err_exp++;
        tick(); idle_in();
        chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_err", {31'd0, lsu_err}, 32'd1);
        drive(1, 1, 32'h300, 32'h0, 32'h0, 1, 5'd9);
        err_exp++;
        tick(); idle_in();
        chk("ill_no_req", {31'd0, dmem_req}, 32'd0);
        chk("ill_err", {31'd0, lsu_err}, 32'd1);
        drive(1, 0, 32'h104, 32'h0, 32'h0, 1, 5'd0);
        wb_q.push_back('{5'd0, 1'b0, 32'hCAFE_0001});
        tick(); idle_in();
        chk("x0_req", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_0001;
        tick(); dmem_ack = 1'b0;
        chk("x0_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("x0_wb_we", {31'd0, wb_we}, 32'd0);

        // Stray ack while idle must do nothing.
        tick(); dmem_ack = 1'b1;
        tick(); dmem_ack = 1'b0;
        chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("stray_ack_wb", {31'd0, wb_valid}, 32'd0);

        // Reset in the middle of a request.
        drive(1, 0, 32'h400, 32'h0, 32'h0, 1, 5'd5);
        tick(); idle_in();
        chk("mid_req", {31'd0, dmem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("async_ready", {31'd0, alu_ready}, 32'd1);
        tick(); tick();
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        tick(); dmem_ack = 1'b0;
        tick(); tick();

`ifdef LSU_TIMEOUT_EN
        begin
            int req_cyc;
            req_cyc = 0;
            drive(1, 0, 32'h500, 32'h0, 32'h0, 1, 5'd6);
            err_exp++;
            tick(); idle_in();
            while (dmem_req && req_cyc < 20) begin
                req_cyc++;
                tick();
            end
            chk("to_req_cycles", req_cyc, 32'd4);
            chk("to_err", {31'd0, lsu_err}, 32'd1);
            chk("to_idle", {31'd0, alu_ready}, 32'd1);
            tick();
        end
`endif

        tick(); tick();
        chk("wb_q_drained", wb_q.size(), 32'd0);
        chk("err_drained", err_exp, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/store and writeback stage of the RISC-V core, directly downstream of the ALU. It accepts one ALU result per handshake. Loads and stores go out as a single-word request to data memory, waiting for the memory acknowledge. Register writes (ALU results or load data) go back to the register file as a one-cycle writeback pulse. While a memory access is outstanding, the stage stalls the ALU.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles to wait for dmem_ack (used only with LSU_TIMEOUT_EN).

Ports:
- clk  input  1  single clock for the block; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU presents an operation.
- alu_ready  output  1  stage can accept; high only in IDLE.
- alu_result  input  32  ALU result, written back for non-memory ops.
- alu_mem_addr  input  32  byte address for load/store.
- alu_store_data  input  32  store data (rs2 value).
- alu_load  input  1  operation is a word load.
- alu_store  input  1  operation is a word store.
- alu_reg_we  input  1  operation writes rd.
- alu_rd  input  5  destination register index.
- dmem_req  output  1  memory request, held until ack.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  32  word-aligned address.
- dmem_wdata  output  32  store data.
- dmem_ack  input  1  memory completes the request this cycle.
- dmem_rdata  input  32  load data, valid with dmem_ack.
- wb_valid  output  1  one-cycle writeback pulse.
- wb_we  output  1  register-file write enable; 0 when rd = 0.
- wb_rd  output  5  writeback register index.
- wb_data  output  32  writeback value.
- lsu_err  output  1  one-cycle error pulse (misaligned, illegal, or timeout).

## Operation
- States: IDLE, REQ.
- Accept condition: alu_valid & alu_ready.
- Non-memory op accepted:
  - If alu_reg_we, the next cycle has wb_valid = 1, wb_data = alu_result, wb_rd = alu_rd.
  - State stays IDLE, so back-to-back accepts are allowed.
- Load/store accepted, aligned:
  - The stage latches the address, data and rd, then goes to REQ.
  - In REQ, dmem_req = 1, with dmem_we, dmem_addr and dmem_wdata stable until ack.
- dmem_ack in REQ:
  - Next state is IDLE.
  - A load produces wb_valid next cycle with wb_data = dmem_rdata (the value captured at ack).
  - A store produces no writeback pulse.
- alu_mem_addr[1:0] != 0 on a load/store:
  - No memory request and no writeback.
  - lsu_err pulses the next cycle; state stays IDLE.
- alu_load & alu_store both set: treated as illegal and handled the same as misaligned.
- rd = 0: wb_valid still pulses, but wb_we = 0. Otherwise wb_we = wb_valid.
- dmem_ack outside REQ is ignored.
- Reset values: all outputs are 0 except alu_ready = 1; state = IDLE.
- Reset mid-REQ drops dmem_req immediately (asynchronous) and discards the pending op.

## Timing
- Non-memory op: accept at cycle N, wb_valid at cycle N+1.
- Load: accept at N, dmem_req from N+1. With ack at cycle M (M >= N+1), wb_valid is at M+1 and alu_ready is high again at M+1.
- Store: accept at N, dmem_req from N+1, ack at M, alu_ready at M+1.
- Minimum occupancy of a memory op: 2 cycles.
- wb_valid and lsu_err are never high for more than one consecutive cycle per op, and are never high together.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter runs in REQ; it clears on entry to REQ.
  - If TIMEOUT_CYCLES cycles pass in REQ without dmem_ack, dmem_req drops, lsu_err pulses, no writeback occurs, and the stage returns to IDLE.
- LSU_TIMEOUT_EN undefined:
  - No counter; REQ waits for dmem_ack indefinitely.
  - The TIMEOUT_CYCLES parameter is unused.

## Structure
- Package lsu_pkg holds:
  - the state enum (IDLE, REQ);
  - XLEN = 32 and REG_IDX_W = 5;
  - the constant for the address alignment mask.
- One sub-module, lsu_timeout_ctr: a counter with clear/enable/expired, instantiated only under LSU_TIMEOUT_EN.

## Test plan
- Reset, then two ALU ops back-to-back (rd=3, 0x0005; rd=4, 0x000F) -> wb_valid on consecutive cycles with those values; alu_ready stays 1.
- Load at 0x100, memory acks 3 cycles later with 0xDEADBEEF -> dmem_req held for 3 cycles, alu_ready = 0 during REQ, wb_data = 0xDEADBEEF one cycle after ack.
- Store 0x12345678 to 0x200 with ack in the same cycle as the request -> dmem_we = 1, no wb_valid, alu_ready returns after 2 cycles.
- Load to 0x102, then load with rd = 0 -> first: lsu_err pulse and no dmem_req; second: wb_valid = 1 with wb_we = 0.
- rst asserted mid-REQ -> dmem_req falls without a clock edge; no writeback after reset releases.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, load never acked -> lsu_err after 4 REQ cycles, then IDLE.
